// File: rtl/kd_tree_root_ctrl.sv
// rtl/kd_tree_root_ctrl.sv - root controller for the k-d tree sorting network
// Configures the tree, runs the sort, then streams query points one at a time.
module kd_tree_root_ctrl #(
    parameter int DIM     = 3,
    parameter int WIDTH   = 16,
    parameter int DEPTH_W = 4,
    parameter int CMD_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DEPTH_W-1:0]     depth_in,
    input  logic [1:0]             axis_in,
    output logic [CMD_W-1:0]       command_to_node,
    output logic [DIM*WIDTH-1:0]   data_to_node,
    input  logic [CMD_W-1:0]       command_from_node,
    input  logic [DIM*WIDTH-1:0]   data_from_node,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    input  logic [DIM*WIDTH-1:0]   pt_data,
    output logic                   res_valid,
    output logic [DIM*WIDTH-1:0]   res_data,
    output logic                   busy,
    output logic                   sorted,
    output logic                   error
);
    localparam int DW    = DIM * WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [CMD_W-1:0] CMD_NOP        = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_CFG_DEPTH  = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_SORT_ACK   = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_START_SORT = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_SORT_DONE  = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_POINT      = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_POINT_ACK  = CMD_W'(8);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_WAIT_ACK, S_START, S_SORTING,
        S_READY, S_SEND_PT, S_WAIT_PT, S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [DW-1:0]      data_q, data_d;
    logic               res_valid_q, res_valid_d;
    logic [DW-1:0]      res_data_q, res_data_d;
    logic               pt_ready_q, busy_q, sorted_q, error_q;
    logic [DW-1:0]      cfg_word;
    logic               timed_out, waiting_d;

    // Configure word: time_to_live starts at 0, then axis, then depth.
    always_comb begin
        cfg_word = '0;
        cfg_word[DEPTH_W+1:DEPTH_W]     = axis_in;
        cfg_word[2*DEPTH_W+1:DEPTH_W+2] = depth_in;
    end

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cmd_d       = CMD_NOP;
        data_d      = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CFG;
                    cmd_d   = CMD_CFG_DEPTH;
                    data_d  = cfg_word;
                end
            end
            S_CFG:   state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (command_from_node == CMD_SORT_ACK) begin
                    state_d = S_START;
                    cmd_d   = CMD_START_SORT;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_START: state_d = S_SORTING;
            S_SORTING: begin
                if (command_from_node == CMD_SORT_DONE) state_d = S_READY;
                else if (timed_out)                     state_d = S_ERROR;
            end
            S_READY: begin
                // Reconfiguration has priority over a pending point.
                if (start) begin
                    state_d = S_CFG;
                    cmd_d   = CMD_CFG_DEPTH;
                    data_d  = cfg_word;
                end else if (pt_valid) begin
                    state_d = S_SEND_PT;
                    cmd_d   = CMD_POINT;
                    data_d  = pt_data;
                end
            end
            S_SEND_PT: state_d = S_WAIT_PT;
            S_WAIT_PT: begin
                if (command_from_node == CMD_POINT_ACK) begin
                    state_d     = S_READY;
                    res_valid_d = 1'b1;
                    res_data_d  = data_from_node;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    assign waiting_d = (state_d == S_WAIT_ACK) || (state_d == S_SORTING) || (state_d == S_WAIT_PT);

    always_comb begin
        cnt_d = '0;
        if (waiting_d && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= CMD_NOP;
            data_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            pt_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            sorted_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            pt_ready_q  <= (state_d == S_READY);
            busy_q      <= !((state_d == S_IDLE) || (state_d == S_READY) || (state_d == S_ERROR));
            sorted_q    <= (state_d == S_READY);
            error_q     <= (state_d == S_ERROR);
        end
    end

    assign command_to_node = cmd_q;
    assign data_to_node    = data_q;
    assign pt_ready        = pt_ready_q && !start;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign busy            = busy_q;
    assign sorted          = sorted_q;
    assign error           = error_q;
endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// tb/tb_kd_tree_root_ctrl.sv - scoreboard bench for kd_tree_root_ctrl
// Stimulus queues expected node commands and results; a monitor pops and compares them.
module tb_kd_tree_root_ctrl;
    localparam int TIMEOUT = 1024;
    localparam logic [3:0] NOP = 4'd0, CFG = 4'd1, SACK = 4'd2, SSORT = 4'd3,
                           SDONE = 4'd6, PNT = 4'd7, PACK = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  depth_in;
    logic [1:0]  axis_in;
    logic [3:0]  command_to_node;
    logic [47:0] data_to_node;
    logic [3:0]  command_from_node;
    logic [47:0] data_from_node;
    logic        pt_valid;
    logic        pt_ready;
    logic [47:0] pt_data;
    logic        res_valid;
    logic [47:0] res_data;
    logic        busy, sorted, error;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [47:0] data;
    } cmd_t;

    cmd_t        exp_cmd_q[$];
    logic [47:0] exp_res_q[$];
    int          checks = 0;
    int          errors = 0;

    kd_tree_root_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .depth_in(depth_in), .axis_in(axis_in),
        .command_to_node(command_to_node), .data_to_node(data_to_node),
        .command_from_node(command_from_node), .data_from_node(data_from_node),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .sorted(sorted), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] c, input logic [47:0] d);
        cmd_t e;
        e.cmd  = c;
        e.data = d;
        exp_cmd_q.push_back(e);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd"},       command_to_node, NOP);
        chk({tag, "_data"},      data_to_node, 0);
        chk({tag, "_pt_ready"},  pt_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"},  res_data, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_sorted"},    sorted, 0);
        chk({tag, "_error"},     error, 0);
    endtask

    // Monitor: every non-NOP command and every result pulse must match the queue head.
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (command_to_node != NOP) begin
                    if (exp_cmd_q.size() == 0) begin
                        chk("unexpected_cmd", command_to_node, NOP);
                    end else begin
                        e = exp_cmd_q.pop_front();
                        chk("sb_cmd", command_to_node, e.cmd);
                        chk("sb_data", data_to_node, e.data);
                    end
                end
                if (res_valid) begin
                    if (exp_res_q.size() == 0) chk("unexpected_res", 1, 0);
                    else                       chk("sb_res_data", res_data, exp_res_q.pop_front());
                end
            end
        end
    end

    logic [47:0] pts  [8];
    logic [47:0] resp [8];

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            pts[i]  = {16'(i + 1), 16'(16 * i + 3), 16'hA000 + 16'(i)};
            resp[i] = {16'h00C0 + 16'(i), 16'(i * 7), 16'hBEEF};
        end
        rst = 1'b1; start = 1'b0; depth_in = '0; axis_in = '0;
        command_from_node = NOP; data_from_node = '0; pt_valid = 1'b0; pt_data = '0;
        repeat (2) tick();
        @(negedge clk);
        chk_reset_values("reset");
        tick();
        rst = 1'b0;

        // Configure: depth 3 at [9:6], axis 1 at [5:4], ttl 0
        start = 1'b1; depth_in = 4'd3; axis_in = 2'd1;
        push_cmd(CFG, 48'h0D0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("cfg_cycle", command_to_node, CFG);
        chk("cfg_busy", busy, 1);
        tick();
        command_from_node = PACK; data_from_node = 48'hDEAD;
        @(negedge clk);
        chk("cfg_one_cycle", command_to_node, NOP);
        tick();
        command_from_node = NOP;
        tick();
        tick();
        command_from_node = SACK;
        push_cmd(SSORT, 48'h0);
        @(negedge clk);
        chk("spurious_pack_busy", busy, 1);
        chk("spurious_pack_sorted", sorted, 0);
        tick();
        command_from_node = NOP;
        @(negedge clk);
        chk("start_sort_cycle", command_to_node, SSORT);
        tick();
        @(negedge clk);
        chk("start_sort_one_cycle", command_to_node, NOP);
        tick();
        command_from_node = SDONE;
        tick();
        command_from_node = NOP;
        @(negedge clk);
        chk("ready_sorted", sorted, 1);
        chk("ready_busy", busy, 0);
        chk("ready_pt_ready", pt_ready, 1);

        // Single point round trip with a spurious SORT_DONE while waiting
        pt_valid = 1'b1; pt_data = 48'h0001_0002_0003;
        push_cmd(PNT, 48'h0001_0002_0003);
        tick();
        pt_valid = 1'b0;
        @(negedge clk);
        chk("point_cycle", command_to_node, PNT);
        chk("point_pt_ready", pt_ready, 0);
        chk("point_sorted", sorted, 0);
        tick();
        command_from_node = SDONE;
        tick();
        command_from_node = PACK; data_from_node = 48'h0005_0005_0005;
        exp_res_q.push_back(48'h0005_0005_0005);
        @(negedge clk);
        chk("spurious_sdone_busy", busy, 1);
        chk("spurious_sdone_res_valid", res_valid, 0);
        tick();
        command_from_node = NOP;
        @(negedge clk);
        chk("res_valid_pulse", res_valid, 1);
        chk("res_data", res_data, 48'h0005_0005_0005);
        chk("res_pt_ready", pt_ready, 1);
        tick();
        @(negedge clk);
        chk("res_valid_one_cycle", res_valid, 0);

        // Eight points with pt_valid held high
        tick();
        pt_valid = 1'b1; pt_data = pts[0];
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!pt_ready && n < 20) begin
                tick();
                n++;
            end
            if (i > 0) chk("b2b_throughput_wait", n, 0);
            push_cmd(PNT, pts[i]);
            exp_res_q.push_back(resp[i]);
            tick();
            if (i < 7) pt_data = pts[i + 1];
            else       pt_valid = 1'b0;
            chk("b2b_pt_ready_low", pt_ready, 0);
            tick();
            command_from_node = PACK; data_from_node = resp[i];
            chk("b2b_pt_ready_wait", pt_ready, 0);
            tick();
            command_from_node = NOP;
        end

        // Simultaneous start and pt_valid in READY: reconfiguration wins
        start = 1'b1; pt_valid = 1'b1; pt_data = 48'h0123; depth_in = 4'd5; axis_in = 2'd2;
        push_cmd(CFG, 48'h160);
        #1;
        chk("start_masks_pt_ready", pt_ready, 0);
        tick();
        start = 1'b0; pt_valid = 1'b0;
        @(negedge clk);
        chk("restart_cfg", command_to_node, CFG);
        tick();
        command_from_node = SACK;
        push_cmd(SSORT, 48'h0);
        tick();
        command_from_node = NOP;
        tick();
        @(negedge clk);
        chk("sorting_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values("mid_rst");

        // Timeout in WAIT_ACK
        tick();
        start = 1'b1; depth_in = 4'd2; axis_in = 2'd3;
        push_cmd(CFG, 48'h0B0);
        tick();
        start = 1'b0;
        tick();
        repeat (TIMEOUT - 1) tick();
        @(negedge clk);
        chk("timeout_not_yet", error, 0);
        tick();
        @(negedge clk);
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_cmd", command_to_node, NOP);
        start = 1'b1;
        tick();
        start = 1'b0;
        command_from_node = SACK;
        @(negedge clk);
        chk("error_ignores_start", command_to_node, NOP);
        tick();
        command_from_node = NOP;
        tick();
        @(negedge clk);
        chk("error_sticky", error, 1);
        chk("error_pt_ready", pt_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_clears_error", error, 0);
        chk("rst_clears_cmd", command_to_node, NOP);

        tick();
        chk("cmd_queue_drained", exp_cmd_q.size(), 0);
        chk("res_queue_drained", exp_res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
